// File: rtl/dmem_pkg.sv
// Shared encodings for the multi-cycle data memory: transfer sizes and FSM states.
package dmem_pkg;

    // Transfer size is encoded as (bytes - 1); 2 has no legal meaning.
    localparam logic [1:0] DSZ_BYTE = 2'd0;
    localparam logic [1:0] DSZ_HALF = 2'd1;
    localparam logic [1:0] DSZ_INV  = 2'd2;
    localparam logic [1:0] DSZ_WORD = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/dmem_array.sv
// Byte storage organised as 32-bit words with four byte lanes.
// Lane 3 (bits 31:24) holds the lowest byte address of each word.
module dmem_array #(
    parameter int WORDS = 4096,
    parameter int IW    = 12
) (
    input  logic          clk,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic [IW-1:0] idx,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem_r [WORDS];

    // Synchronous byte-lane write; contents are deliberately never reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we && be[i]) begin
                mem_r[idx][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = mem_r[idx];

endmodule

// File: rtl/dmem_multicycle.sv
// Multi-cycle big-endian data memory with programmable wait states.
// Requests are captured in IDLE, checked for alignment/range, held for
// WAIT_STATES+1 cycles in WAIT, then answered with a one-cycle ready pulse.
module dmem_multicycle
    import dmem_pkg::*;
#(
    parameter int SIZE        = 16384,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [1:0]  dsize,
    input  logic        sext,
    output logic        busy,
    output logic        ready,
    output logic [31:0] rdata,
    output logic        err
);

    localparam int          AW       = $clog2(SIZE);
    localparam int          IW       = AW - 2;
    localparam logic [32:0] SIZE_EXT = 33'(SIZE);
    localparam logic [3:0]  WS_INIT  = 4'(WAIT_STATES);

    // Misalignment, the unused size code, or any byte beyond the array.
    function automatic logic is_bad_request(input logic [31:0] a, input logic [1:0] dsz);
        logic bad;
        case (dsz)
            DSZ_HALF: bad = a[0];
            DSZ_WORD: bad = (a[1:0] != 2'b00);
            DSZ_BYTE: bad = 1'b0;
            default:  bad = 1'b1;
        endcase
        return bad || (({1'b0, a} + {31'b0, dsz}) >= SIZE_EXT);
    endfunction

    // Byte lanes touched by an access; lane 3 is the lowest address.
    function automatic logic [3:0] lane_enable(input logic [1:0] off, input logic [1:0] dsz);
        logic [3:0] be;
        case (dsz)
            DSZ_BYTE: be = 4'b1000 >> off;
            DSZ_HALF: be = off[1] ? 4'b0011 : 4'b1100;
            DSZ_WORD: be = 4'b1111;
            default:  be = 4'b0000;
        endcase
        return be;
    endfunction

    // Replicate the right-aligned write data across every lane it may land in.
    function automatic logic [31:0] lane_data(input logic [31:0] d, input logic [1:0] dsz);
        logic [31:0] res;
        case (dsz)
            DSZ_BYTE: res = {4{d[7:0]}};
            DSZ_HALF: res = {2{d[15:0]}};
            DSZ_WORD: res = d;
            default:  res = 32'd0;
        endcase
        return res;
    endfunction

    // Pick the addressed bytes out of the word, right-align and extend them.
    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] off,
                                                input logic [1:0] dsz, input logic sx);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        case (off)
            2'd0:    b = word[31:24];
            2'd1:    b = word[23:16];
            2'd2:    b = word[15:8];
            default: b = word[7:0];
        endcase
        h = off[1] ? word[15:0] : word[31:16];
        case (dsz)
            DSZ_BYTE: res = {{24{sx & b[7]}}, b};
            DSZ_HALF: res = {{16{sx & h[15]}}, h};
            DSZ_WORD: res = word;
            default:  res = 32'd0;
        endcase
        return res;
    endfunction

    state_t        state_r, state_next_s;
    logic [3:0]    cnt_r, cnt_next_s;
    logic          we_q_r;
    logic [AW-1:0] addr_q_r;
    logic [31:0]   wdata_q_r;
    logic [1:0]    dsize_q_r;
    logic          sext_q_r;
    logic          busy_r, ready_r, err_r;
    logic [31:0]   rdata_r;
    logic          ready_next_s, err_next_s;
    logic [31:0]   rdata_next_s;
    logic          cap_en_s, mem_we_s, req_err_s;
    logic [3:0]    mem_be_s;
    logic [31:0]   mem_wdata_s, mem_rdata_s;

    assign req_err_s   = is_bad_request(addr, dsize);
    assign mem_be_s    = lane_enable(addr_q_r[1:0], dsize_q_r);
    assign mem_wdata_s = lane_data(wdata_q_r, dsize_q_r);

    dmem_array #(
        .WORDS (SIZE / 4),
        .IW    (IW)
    ) u_array (
        .clk   (clk),
        .we    (mem_we_s),
        .be    (mem_be_s),
        .idx   (addr_q_r[AW-1:2]),
        .wdata (mem_wdata_s),
        .rdata (mem_rdata_s)
    );

    // Next-state, counter and response decode.
    // An error request enters RESP with ready still low and raises ready on
    // the following cycle, so ready always lands one edge after the access
    // edge and busy stays high for the whole response.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        ready_next_s = 1'b0;
        err_next_s   = 1'b0;
        rdata_next_s = rdata_r;
        cap_en_s     = 1'b0;
        mem_we_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (req) begin
                    cap_en_s = 1'b1;
                    if (req_err_s) begin
                        state_next_s = RESP;
                    end else begin
                        state_next_s = WAIT;
                        cnt_next_s   = WS_INIT;
                    end
                end else begin
                    state_next_s = IDLE;
                end
            end
            WAIT: begin
                if (cnt_r == 4'd0) begin
                    state_next_s = RESP;
                    ready_next_s = 1'b1;
                    if (we_q_r) begin
                        mem_we_s     = 1'b1;
                        rdata_next_s = 32'd0;
                    end else begin
                        rdata_next_s = load_extend(mem_rdata_s, addr_q_r[1:0], dsize_q_r, sext_q_r);
                    end
                end else begin
                    cnt_next_s = cnt_r - 4'd1;
                end
            end
            RESP: begin
                if (ready_r) begin
                    state_next_s = IDLE;
                end else begin
                    ready_next_s = 1'b1;
                    err_next_s   = 1'b1;
                    rdata_next_s = 32'd0;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Wait counter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r   <= 4'd0;
            busy_r  <= 1'b0;
            ready_r <= 1'b0;
            err_r   <= 1'b0;
            rdata_r <= 32'd0;
        end else begin
            cnt_r   <= cnt_next_s;
            busy_r  <= (state_next_s != IDLE);
            ready_r <= ready_next_s;
            err_r   <= err_next_s;
            rdata_r <= rdata_next_s;
        end
    end

    // Request capture, only when a request is accepted in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q_r    <= 1'b0;
            addr_q_r  <= '0;
            wdata_q_r <= 32'd0;
            dsize_q_r <= 2'd0;
            sext_q_r  <= 1'b0;
        end else if (cap_en_s) begin
            we_q_r    <= we;
            addr_q_r  <= addr[AW-1:0];
            wdata_q_r <= wdata;
            dsize_q_r <= dsize;
            sext_q_r  <= sext;
        end
    end

    assign busy  = busy_r;
    assign ready = ready_r;
    assign err   = err_r;
    assign rdata = rdata_r;

endmodule

// File: tb/tb_dmem_multicycle.sv
// Bench for dmem_multicycle: a transaction-level model (byte array plus
// accept/complete edge arithmetic) checked every cycle, with directed
// literal scenarios and a randomized phase.
module tb_dmem_multicycle;

    localparam int SIZE = 16384;
    localparam int WS   = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b0;
    logic        req = 1'b0, we = 1'b0, sext = 1'b0;
    logic [31:0] addr = 32'd0, wdata = 32'd0;
    logic [1:0]  dsize = 2'd0;
    logic        busy, ready, err;
    logic [31:0] rdata;

    logic        req0 = 1'b0, we0 = 1'b1, sext0 = 1'b0;
    logic [31:0] addr0 = 32'd0, wdata0 = 32'h12345678;
    logic [1:0]  dsize0 = 2'd3;
    logic        busy0, ready0, err0;
    logic [31:0] rdata0;

    dmem_multicycle #(.SIZE(SIZE), .WAIT_STATES(WS)) u_dut (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .dsize(dsize), .sext(sext), .busy(busy), .ready(ready), .rdata(rdata), .err(err)
    );

    dmem_multicycle #(.SIZE(SIZE), .WAIT_STATES(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0),
        .dsize(dsize0), .sext(sext0), .busy(busy0), .ready(ready0), .rdata(rdata0), .err(err0)
    );

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_on   = 1'b0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual %h required %h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [31:0] init_val(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
    endfunction

    // ---------------- behavioural model ----------------
    logic [7:0]  mdl_mem [SIZE];
    int          cyc = 0, last_acc = -1, last_done = -1;
    bit          p_pend = 1'b0, p_we, p_err, p_sx;
    logic [31:0] p_addr, p_wdata, m_v;
    logic [1:0]  p_dsz;
    bit          exp_busy = 1'b0, exp_ready = 1'b0, exp_err = 1'b0;
    logic [31:0] exp_rdata = 32'd0;

    function automatic bit mdl_is_err(input logic [31:0] a, input logic [1:0] s);
        longint last_byte;
        last_byte = longint'(a) + longint'(s);
        return (s == 2'd2) || (s == 2'd1 && a[0]) || (s == 2'd3 && a[1:0] != 2'd0) ||
               (last_byte >= longint'(SIZE));
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc = 0; last_acc = -1; last_done = -1; p_pend = 1'b0;
            exp_busy = 1'b0; exp_ready = 1'b0; exp_err = 1'b0; exp_rdata = 32'd0;
        end else begin
            cyc++;
            exp_ready = 1'b0;
            exp_err   = 1'b0;
            if (p_pend && cyc == last_done) begin
                p_pend    = 1'b0;
                exp_ready = 1'b1;
                exp_err   = p_err;
                if (p_err || p_we) begin
                    exp_rdata = 32'd0;
                    if (!p_err) begin
                        for (int i = 0; i <= int'(p_dsz); i++)
                            mdl_mem[int'(p_addr) + i] = 8'(p_wdata >> (8 * (int'(p_dsz) - i)));
                    end
                end else begin
                    m_v = 32'd0;
                    for (int i = 0; i <= int'(p_dsz); i++)
                        m_v = (m_v << 8) | {24'd0, mdl_mem[int'(p_addr) + i]};
                    if (p_dsz == 2'd0 && p_sx && m_v[7])  m_v = m_v | 32'hFFFFFF00;
                    if (p_dsz == 2'd1 && p_sx && m_v[15]) m_v = m_v | 32'hFFFF0000;
                    exp_rdata = m_v;
                end
            end
            if (req && cyc >= last_done + 2) begin
                p_pend = 1'b1; p_we = we; p_addr = addr; p_wdata = wdata;
                p_dsz = dsize; p_sx = sext; p_err = mdl_is_err(addr, dsize);
                last_acc  = cyc;
                last_done = cyc + (p_err ? 1 : WS + 1);
            end
            exp_busy = (last_acc >= 0) && (cyc >= last_acc) && (cyc <= last_done);
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            check32("busy", 32'(busy), 32'(exp_busy));
            check32("ready", 32'(ready), 32'(exp_ready));
            if (exp_ready) check32("err", 32'(err), 32'(exp_err));
            check32("rdata", rdata, exp_rdata);
        end
    end

    // One transaction on the WAIT_STATES=2 instance; returns latency in edges.
    task automatic xact(input bit w, input logic [31:0] a, input logic [31:0] d,
                        input logic [1:0] sz, input bit sx,
                        output int lat, output logic [31:0] rd, output bit e);
        @(negedge clk);
        req = 1'b1; we = w; addr = a; wdata = d; dsize = sz; sext = sx;
        @(negedge clk);
        req = 1'b0;
        lat = 0;
        while (ready !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (lat >= 40) begin
            n_checks++;
            $display("FAIL timeout: no ready within 40 cycles for addr %h", a);
        end
        rd = rdata;
        e  = err;
    endtask

    int          lat;
    logic [31:0] rd;
    bit          e;
    int          r;

    initial begin
        repeat (3) @(negedge clk);
        check32("rst_busy", 32'(busy), 32'd0);
        check32("rst_ready", 32'(ready), 32'd0);
        check32("rst_err", 32'(err), 32'd0);
        check32("rst_rdata", rdata, 32'd0);
        check32("rst_busy0", 32'(busy0), 32'd0);
        rst_n  = 1'b1;
        chk_on = 1'b1;

        // Zero wait states with req held high: accept on edges 1,4,7,10.
        @(negedge clk);
        req0 = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            check32("ws0_ready", 32'(ready0), 32'((k % 3) == 2));
            check32("ws0_busy", 32'(busy0), 32'((k % 3) != 0));
        end
        req0 = 1'b0;
        check32("ws0_rdata", rdata0, 32'd0);

        // Initialise the low window and the top window of the array.
        for (int a = 0; a < 'h400; a += 4) xact(1'b1, 32'(a), init_val(32'(a)), 2'd3, 1'b0, lat, rd, e);
        for (int a = SIZE - 16; a < SIZE; a += 4) xact(1'b1, 32'(a), init_val(32'(a)), 2'd3, 1'b0, lat, rd, e);

        xact(1'b1, 32'h100, 32'hDEADBEEF, 2'd3, 1'b0, lat, rd, e);
        check32("ww_lat", 32'(lat), 32'd3);
        check32("ww_err", 32'(e), 32'd0);
        check32("ww_rdata", rd, 32'd0);
        xact(1'b0, 32'h100, 32'd0, 2'd3, 1'b0, lat, rd, e);
        check32("wr_lat", 32'(lat), 32'd3);
        check32("wr_rdata", rd, 32'hDEADBEEF);
        xact(1'b1, 32'h101, 32'h00000080, 2'd0, 1'b0, lat, rd, e);
        xact(1'b0, 32'h101, 32'd0, 2'd0, 1'b1, lat, rd, e);
        check32("rb_sext", rd, 32'hFFFFFF80);
        xact(1'b0, 32'h101, 32'd0, 2'd0, 1'b0, lat, rd, e);
        check32("rb_zext", rd, 32'h00000080);
        xact(1'b0, 32'h100, 32'd0, 2'd3, 1'b0, lat, rd, e);
        check32("rw_merge", rd, 32'hDE80BEEF);

        xact(1'b0, 32'h103, 32'd0, 2'd1, 1'b0, lat, rd, e);
        check32("half_mis_err", 32'(e), 32'd1);
        check32("half_mis_lat", 32'(lat), 32'd1);
        check32("half_mis_rdata", rd, 32'd0);
        xact(1'b0, 32'h102, 32'd0, 2'd3, 1'b0, lat, rd, e);
        check32("word_mis_err", 32'(e), 32'd1);
        check32("word_mis_lat", 32'(lat), 32'd1);
        xact(1'b1, 32'h103, 32'h0000FFFF, 2'd1, 1'b0, lat, rd, e);
        xact(1'b0, 32'h100, 32'd0, 2'd3, 1'b0, lat, rd, e);
        check32("mis_nowrite", rd, 32'hDE80BEEF);

        xact(1'b1, 32'h0, 32'hFFFFFFFF, 2'd2, 1'b0, lat, rd, e);
        check32("dsz2_err", 32'(e), 32'd1);
        xact(1'b0, 32'h0, 32'd0, 2'd3, 1'b0, lat, rd, e);
        check32("dsz2_nowrite", rd, 32'h5A5AFFFF);
        xact(1'b1, 32'(SIZE - 2), 32'h11111111, 2'd3, 1'b0, lat, rd, e);
        check32("top_word_err", 32'(e), 32'd1);
        xact(1'b0, 32'(SIZE - 4), 32'd0, 2'd3, 1'b0, lat, rd, e);
        check32("top_nowrite", rd, 32'h65A6C003);
        xact(1'b0, 32'(SIZE - 1), 32'd0, 2'd0, 1'b0, lat, rd, e);
        check32("top_byte_ok", rd, 32'h00000003);
        xact(1'b0, 32'(SIZE), 32'd0, 2'd0, 1'b0, lat, rd, e);
        check32("past_end_err", 32'(e), 32'd1);

        // Reset during WAIT aborts the write.
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = 32'h200; wdata = 32'hAAAAAAAA; dsize = 2'd3;
        @(negedge clk);
        req = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        check32("abort_busy", 32'(busy), 32'd0);
        check32("abort_ready", 32'(ready), 32'd0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        xact(1'b0, 32'h200, 32'd0, 2'd3, 1'b0, lat, rd, e);
        check32("abort_first_lat", 32'(lat), 32'd3);
        check32("abort_nowrite", rd, init_val(32'h200));

        // Randomized traffic, including requests while busy.
        repeat (3000) begin
            @(negedge clk);
            req   = ($urandom_range(0, 2) == 0);
            we    = 1'($urandom_range(0, 1));
            dsize = 2'($urandom_range(0, 3));
            sext  = 1'($urandom_range(0, 1));
            wdata = $urandom;
            r = int'($urandom_range(0, 9));
            if (r < 7)      addr = 32'($urandom_range(0, 'h3FF));
            else if (r < 9) addr = 32'(SIZE - 8 + int'($urandom_range(0, 11)));
            else            addr = $urandom;
        end
        req = 1'b0;
        repeat (20) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dmem_multicycle.md
DMEM_MULTICYCLE -- requirements
Module: dmem_multicycle

Interface
REQ-001 Parameter: SIZE, 16384, memory capacity in bytes; SHALL be a multiple of 4.
REQ-002 Parameter: WAIT_STATES, 2, extra cycles between request acceptance and access; legal range 0..15.
REQ-003 Port: clk  in  1  sole clock; all state updates on rising edge.
REQ-004 Port: rst_n  in  1  asynchronous, active-low reset.
REQ-005 Port: req  in  1  access request, sampled only in IDLE.
REQ-006 Port: we  in  1  1 = write, 0 = read.
REQ-007 Port: addr  in  32  byte address, big-endian byte order.
REQ-008 Port: wdata  in  32  write data; byte uses bits [24:31], halfword uses [16:31], word uses all 32 bits.
REQ-009 Port: dsize  in  2  bytes-1 encoding: 3 = word, 1 = halfword, 0 = byte, 2 = invalid.
REQ-010 Port: sext  in  1  1 = sign-extend byte/halfword reads, 0 = zero-extend.
REQ-011 Port: busy  out  1  high whenever state is not IDLE.
REQ-012 Port: ready  out  1  one-cycle completion pulse.
REQ-013 Port: rdata  out  32  registered read result.
REQ-014 Port: err  out  1  error flag, valid while ready is high.

Function
REQ-015 FSM states SHALL be IDLE, WAIT and RESP.
REQ-016 In IDLE with req=1, the block SHALL capture we, addr, wdata, dsize and sext into internal registers on the same edge.
REQ-017 A captured request SHALL be an error if any of these hold: dsize=2; dsize=1 with addr[31]=1; dsize=3 with addr[30:31]!=0; addr+dsize >= SIZE.
REQ-018 An error request SHALL go IDLE->RESP directly, perform no memory write, and assert err=1 with ready.
REQ-019 A legal request SHALL go IDLE->WAIT and load the wait counter with WAIT_STATES.
REQ-020 In WAIT, the counter SHALL decrement each cycle.
REQ-021 When the counter is 0 in WAIT, the access SHALL be performed on that edge and the FSM SHALL move to RESP.
REQ-022 With WAIT_STATES=0, the FSM SHALL spend exactly one cycle in WAIT.
REQ-023 If a request is accepted at edge T, ready SHALL be high in the cycle following edge T+WAIT_STATES+1 for legal requests, and in the cycle following edge T+1 for error requests.
REQ-024 ready SHALL be high for exactly one cycle, and RESP SHALL always return to IDLE.
REQ-025 Writes SHALL update only the addressed bytes: byte writes mem[addr]; halfword writes mem[addr..addr+1]; word writes mem[addr..addr+3]; the lowest address holds the MSB.
REQ-026 Read results SHALL be right-aligned in rdata and extended per sext; for dsize=3, sext is ignored.
REQ-027 rdata SHALL load 0 on write completion and on error completion, and SHALL otherwise hold its value until the next completion.
REQ-028 req while busy=1 SHALL be ignored: no capture, no queueing.
REQ-029 A request accepted in the same cycle that ready drops SHALL NOT occur; the earliest next acceptance is the cycle after RESP.
REQ-030 A read-after-write to the same address SHALL return the newly written data.

Reset
REQ-031 On rst_n=0, the FSM SHALL go to IDLE immediately (asynchronously).
REQ-032 On rst_n=0, busy, ready and err SHALL be 0; rdata and the wait counter SHALL be 0.
REQ-033 Memory contents SHALL NOT be reset.
REQ-034 A reset asserted during WAIT SHALL abort the access with no memory modification.
REQ-035 After reset release, the first request SHALL be accepted on the first rising edge with req=1.

Structure
REQ-036 Package dmem_pkg SHALL hold the dsize encodings (DSZ_BYTE, DSZ_HALF, DSZ_WORD) and the FSM state type.
REQ-037 One sub-module, dmem_array, SHALL hold the byte storage: synchronous 4-lane byte-enable write and combinational 32-bit read at a word-aligned index.
REQ-038 Alignment, error and extension logic SHALL live in dmem_multicycle.

Verification (WAIT_STATES=2 unless noted)
REQ-039 Word write 0xDEADBEEF @0x100, then word read @0x100 -> rdata=0xDEADBEEF, err=0, ready exactly 3 cycles after each accept.
REQ-040 Byte write 0x80 @0x101, then byte read @0x101 with sext=1 -> rdata=0xFFFFFF80; with sext=0 -> 0x00000080; word read @0x100 -> 0xDE80BEEF.
REQ-041 Halfword read @0x103 and word read @0x102 -> err=1, ready 1 cycle after accept, rdata=0, memory unchanged.
REQ-042 dsize=2 @0x0, and word access @SIZE-2 -> err=1, no write.
REQ-043 Write @0x200 with rst_n pulsed low during WAIT -> busy/ready=0 immediately; subsequent read @0x200 returns the prior contents.
REQ-044 WAIT_STATES=0, back-to-back req held high -> accepts every 3rd cycle, ready every 3rd cycle; req pulses while busy are ignored.
